fft_axil_reg_slave: RTL and testbench
=====================================

// Module: fft_axil_reg_slave
// PURPOSE
//  AXI4-Lite responder for the FFT IP S00_AXI port: terminates single-beat write/read transactions from
//  the PS/VIP master and holds four 32-bit registers (0x0 CTRL, 0x4 CFG, 0x8 SCRATCH0, 0xC SCRATCH1).
//  All registers are read/write, so read-back equals the value last written.
//  Register contents are exported to the FFT datapath, and a one-cycle start pulse is emitted on CTRL writes.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data bus width; only 32 is supported
//  C_S_AXI_ADDR_WIDTH  4   byte address width; bits [3:2] select the register
// PORTS
//  clock          in   1   single clock for all logic
//  reset          in   1   synchronous, active-high reset
//  s_axi_awaddr   in   4   write address
//  s_axi_awprot   in   3   ignored
//  s_axi_awvalid  in   1   write address valid
//  s_axi_awready  out  1   write address accepted
//  s_axi_wdata    in   32  write data
//  s_axi_wstrb    in   4   byte enables; bit n enables wdata[8n+7:8n]
//  s_axi_wvalid   in   1   write data valid
//  s_axi_wready   out  1   write data accepted
//  s_axi_bresp    out  2   always 2'b00 (OKAY)
//  s_axi_bvalid   out  1   write response valid
//  s_axi_bready   in   1   write response accepted
//  s_axi_araddr   in   4   read address
//  s_axi_arprot   in   3   ignored
//  s_axi_arvalid  in   1   read address valid
//  s_axi_arready  out  1   read address accepted
//  s_axi_rdata    out  32  read data
//  s_axi_rresp    out  2   always 2'b00 (OKAY)
//  s_axi_rvalid   out  1   read data valid
//  s_axi_rready   in   1   read data accepted
//  ctrl_o, cfg_o  out  32  live copies of the CTRL and CFG registers
//  start_o        out  1   1-cycle pulse, asserted when a CTRL write commits with wdata[0]=1 and wstrb[0]=1
// BEHAVIOUR
//  Reset: all registers 0; awready, wready, bvalid, arready, rvalid and start_o are 0; rdata is 0.
//  Write FSM, states W_IDLE -> W_ACK -> W_RESP:
//   - W_IDLE: if awvalid && wvalid are both high (sampled in cycle N), go to W_ACK.
//   - W_ACK (cycle N+1): awready = wready = 1 for exactly one cycle. The register write commits at the end of N+1.
//     start_o is high in N+2 when the start condition holds.
//   - W_RESP: bvalid goes high in N+2 and is held until bready is seen high; then return to W_IDLE.
//   - No new AW/W is accepted while bvalid is high.
//   - AW without W, or W without AW, waits; neither ready asserts until both valids are present.
//  Write data:
//   - reg[awaddr[3:2]] byte n <= wdata byte n when wstrb[n]=1; bytes with wstrb[n]=0 are unchanged.
//   - wstrb = 0 completes the handshake and returns OKAY, but no register changes.
//   - awaddr[1:0] are ignored (unaligned accesses are treated as aligned).
//  Read FSM, states R_IDLE -> R_ACK -> R_DATA:
//   - R_IDLE: arvalid sampled high in cycle M -> go to R_ACK.
//   - R_ACK (cycle M+1): arready = 1 for one cycle; rdata is captured from reg[araddr[3:2]] at the end of M+1.
//   - R_DATA: rvalid goes high in M+2. rdata and rvalid are held stable until rready is seen high; then return to R_IDLE.
//  Channel independence: the read and write channels run concurrently.
//   - If a read capture and a write commit hit the same register on the same edge, the read returns the OLD value.
//  Throughput: at most one outstanding transaction per channel; minimum of 3 cycles per transaction with bready/rready tied high.
//  Reset mid-transaction: FSMs return to idle, valids/readys drop next edge, pending response is discarded.
// TESTING
//  1 Reset: reset high for 10 cycles, then low.
//    -> all ready/valid outputs are 0, and reads of 0x0/0x4/0x8/0xC return 0.
//  2 Sequential writes: write 1, 2, 3, 4 to 0x0, 0x4, 0x8, 0xC, then read back.
//    -> data 1, 2, 3, 4; bresp = rresp = 0; start_o pulses once, on the 0x0 write.
//  3 Byte strobes: write 0xAABBCCDD to 0x8 (wstrb = F), then 0x11223344 with wstrb = 4'b0101, then 0xFFFFFFFF with wstrb = 0.
//    -> readback of 0x8 = 0xAA22CC44.
//  4 Backpressure and channel skew: AW presented 4 cycles before W.
//    -> awready and wready assert together, once.
//    Then hold bready low for 6 cycles -> bvalid stays high; a second AW/W is not accepted until B completes.
//    Hold rready low for 5 cycles -> rdata stays stable.
//  5 Same-edge collision: read of 0x4 (old value 0x5) captured on the same edge a write of 0x9 to 0x4 commits.
//    -> rdata = 0x5; next read of 0x4 = 0x9.
//  6 Reset mid-transaction: assert reset while bvalid = 1.
//    -> bvalid = 0 next cycle, registers = 0, and a subsequent write/read works normally.

Source files
------------

// File: rtl/fft_axil_reg_slave_if.sv
// AXI4-Lite bus bundle between the PS/VIP master and the FFT register slave.
// The master drives addresses, data, strobes and valids; the slave answers
// with readies, responses and read data.
interface fft_axil_reg_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  // Write address channel
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic [2:0]          s_axi_awprot;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  // Write data channel
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  // Write response channel
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  // Read address channel
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic [2:0]          s_axi_arprot;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  // Read data channel
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    output s_axi_rready,
    input  s_axi_awready, s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    input  s_axi_rready,
    output s_axi_awready, s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/fft_axil_reg_slave.sv
// AXI4-Lite register slave for the FFT IP S00_AXI port.
// Four read/write 32-bit registers: 0x0 CTRL, 0x4 CFG, 0x8 SCRATCH0, 0xC SCRATCH1.
// Independent write and read FSMs, one outstanding transaction per channel.
// CTRL and CFG are exported live; a CTRL write with bit 0 set (and its byte
// enabled) emits a one-cycle start pulse the cycle after the write commits.
module fft_axil_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,  // only 32 is supported
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  fft_axil_reg_slave_if.slave           s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_o,
  output logic                          start_o
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic                          start_q;

  logic       aw_ready, w_ready, b_valid, w_commit;
  logic       ar_ready, r_valid, r_capture;
  logic [1:0] w_sel, r_sel;
  logic       start_d;

  // Word select: the top two address bits; the byte offset is ignored.
  assign w_sel = s_axi.s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1 -: 2];
  assign r_sel = s_axi.s_axi_araddr[C_S_AXI_ADDR_WIDTH-1 -: 2];

  // Protection bits and byte offsets carry no meaning for this register map.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot,
                           s_axi.s_axi_awaddr[C_S_AXI_ADDR_WIDTH-3:0],
                           s_axi.s_axi_araddr[C_S_AXI_ADDR_WIDTH-3:0]};

  // Write FSM state register.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge
    // values; this is also what makes a same-edge read return the old value.
    if (reset) w_state_q <= W_IDLE;
    else       w_state_q <= w_state_d;
  end

  // Write FSM next state and Moore outputs: both valids must be present before
  // the one-cycle ready pulse; the response is held until bready.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    w_state_d = w_state_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    w_commit  = 1'b0;
    case (w_state_q)
      W_IDLE: if (s_axi.s_axi_awvalid && s_axi.s_axi_wvalid) w_state_d = W_ACK;
      W_ACK: begin
        aw_ready  = 1'b1;
        w_ready   = 1'b1;
        w_commit  = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (s_axi.s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state_q <= R_IDLE;
    else       r_state_q <= r_state_d;
  end

  // Read FSM next state and Moore outputs: accept, capture, then hold data until rready.
  always_comb begin
    r_state_d = r_state_q;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_capture = 1'b0;
    case (r_state_q)
      R_IDLE: if (s_axi.s_axi_arvalid) r_state_d = R_ACK;
      R_ACK: begin
        ar_ready  = 1'b1;
        r_capture = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (s_axi.s_axi_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Register file: byte-lane merge of the write data under the strobes.
  always_ff @(posedge clock) begin
    // NOTE: the register file is cleared on reset because its contents are
    // architecturally visible; plain storage RAMs normally are not reset.
    if (reset) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (w_commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.s_axi_wstrb[b]) regs_q[w_sel][8*b +: 8] <= s_axi.s_axi_wdata[8*b +: 8];
      end
    end
  end

  // Read data capture; held stable through the whole R_DATA phase.
  always_ff @(posedge clock) begin
    if (reset)          rdata_q <= '0;
    else if (r_capture) rdata_q <= regs_q[r_sel];
  end

  // Start pulse: registered so it lands in the cycle after the CTRL write commits.
  assign start_d = w_commit && (w_sel == 2'd0) && s_axi.s_axi_wstrb[0] && s_axi.s_axi_wdata[0];

  always_ff @(posedge clock) begin
    if (reset) start_q <= 1'b0;
    else       start_q <= start_d;
  end

  assign s_axi.s_axi_awready = aw_ready;
  assign s_axi.s_axi_wready  = w_ready;
  assign s_axi.s_axi_bvalid  = b_valid;
  assign s_axi.s_axi_bresp   = 2'b00;
  assign s_axi.s_axi_arready = ar_ready;
  assign s_axi.s_axi_rvalid  = r_valid;
  assign s_axi.s_axi_rresp   = 2'b00;
  assign s_axi.s_axi_rdata   = rdata_q;

  assign ctrl_o  = regs_q[0];
  assign cfg_o   = regs_q[1];
  assign start_o = start_q;

endmodule

// File: tb/tb_fft_axil_reg_slave.sv
// Self-checking bench for fft_axil_reg_slave: directed scenarios followed by
// randomized write/read traffic compared against an array-based register model.
module tb_fft_axil_reg_slave;

  localparam int TIMEOUT = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ctrl_o, cfg_o;
  logic        start_o;

  fft_axil_reg_slave_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  fft_axil_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .s_axi  (bus),
    .ctrl_o (ctrl_o),
    .cfg_o  (cfg_o),
    .start_o(start_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int wr_hs = 0;
  int exp_start = 0;
  int early_ready = 0;
  int aw_seen = 0;
  int ready_skew = 0;
  int start_seen = 0;

  logic [31:0] model [4];
  logic [31:0] rdv, rdv2, exp_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Byte-lane merge rule: enabled bytes come from the new data, others stay.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
    return (old & ~mask) | (d & mask);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model[i] = '0;
  endtask

  // Passive monitor sampled on the falling edge.
  always @(negedge clock) begin
    if (bus.s_axi_awready) aw_seen++;
    if (bus.s_axi_awready !== bus.s_axi_wready) ready_skew++;
    if (start_o) start_seen++;
  end

  task automatic wr_present(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int skew);
    bus.s_axi_awaddr  = a;
    bus.s_axi_awprot  = 3'($urandom);
    bus.s_axi_awvalid = 1'b1;
    for (int i = 0; i < skew; i++) begin
      @(negedge clock);
      if (bus.s_axi_awready || bus.s_axi_wready) early_ready++;
    end
    bus.s_axi_wdata  = d;
    bus.s_axi_wstrb  = s;
    bus.s_axi_wvalid = 1'b1;
  endtask

  // Returns at the falling edge where awready is high; the handshake completes
  // on the following rising edge, so the model is updated here.
  task automatic wr_wait_hs(output bit ok);
    int n;
    logic [1:0] idx;
    @(negedge clock);
    n = 1;
    while (!bus.s_axi_awready && n < TIMEOUT) begin
      @(negedge clock);
      n++;
    end
    ok = bus.s_axi_awready;
    check("aw_handshake", 32'(ok), 32'd1);
    if (ok) begin
      wr_hs++;
      idx = bus.s_axi_awaddr[3:2];
      model[idx] = merge(model[idx], bus.s_axi_wdata, bus.s_axi_wstrb);
      if (idx == 2'd0 && bus.s_axi_wstrb[0] && bus.s_axi_wdata[0]) exp_start++;
    end
  endtask

  task automatic wr_resp(input int hold);
    int n;
    int drops;
    @(negedge clock);
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    n = 0;
    while (!bus.s_axi_bvalid && n < TIMEOUT) begin
      @(negedge clock);
      n++;
    end
    check("bvalid_seen", 32'(bus.s_axi_bvalid), 32'd1);
    drops = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (!bus.s_axi_bvalid) drops++;
    end
    check("bvalid_held", 32'(drops), 32'd0);
    check("bresp", 32'(bus.s_axi_bresp), 32'd0);
    bus.s_axi_bready = 1'b1;
    @(negedge clock);
    bus.s_axi_bready = 1'b0;
    check("bvalid_cleared", 32'(bus.s_axi_bvalid), 32'd0);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int skew, input int hold);
    bit ok;
    @(negedge clock);
    wr_present(a, d, s, skew);
    wr_wait_hs(ok);
    if (ok) wr_resp(hold);
    else begin
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wvalid  = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [3:0] a, input int hold, output logic [31:0] data);
    int n;
    int changes;
    logic [31:0] first;
    @(negedge clock);
    bus.s_axi_araddr  = a;
    bus.s_axi_arprot  = 3'($urandom);
    bus.s_axi_arvalid = 1'b1;
    @(negedge clock);
    n = 1;
    while (!bus.s_axi_arready && n < TIMEOUT) begin
      @(negedge clock);
      n++;
    end
    check("ar_handshake", 32'(bus.s_axi_arready), 32'd1);
    @(negedge clock);
    bus.s_axi_arvalid = 1'b0;
    n = 0;
    while (!bus.s_axi_rvalid && n < TIMEOUT) begin
      @(negedge clock);
      n++;
    end
    check("rvalid_seen", 32'(bus.s_axi_rvalid), 32'd1);
    first = bus.s_axi_rdata;
    changes = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (bus.s_axi_rdata !== first || !bus.s_axi_rvalid) changes++;
    end
    check("rdata_stable", 32'(changes), 32'd0);
    check("rresp", 32'(bus.s_axi_rresp), 32'd0);
    data = bus.s_axi_rdata;
    bus.s_axi_rready = 1'b1;
    @(negedge clock);
    bus.s_axi_rready = 1'b0;
    check("rvalid_cleared", 32'(bus.s_axi_rvalid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, drops, blocked, op, skew, hold;
    bit ok;
    logic [3:0] a, s;
    logic [31:0] d;

    bus.s_axi_awaddr = '0; bus.s_axi_awprot = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata  = '0; bus.s_axi_wstrb  = '0; bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arprot = '0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b0;
    model_reset();

    // 1: reset for 10 cycles, then everything idle and zero.
    reset = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_handshake_outputs",
          32'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid,
               bus.s_axi_arready, bus.s_axi_rvalid, start_o}), 32'd0);
    check("reset_rdata", bus.s_axi_rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), 0, rdv);
      check("reset_readback", rdv, 32'd0);
    end

    // 2: sequential writes 1..4, read back; one start pulse from the CTRL write.
    snap = start_seen;
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    check("seq_start_pulses", 32'(start_seen - snap), 32'd1);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), 0, rdv);
      check("seq_readback", rdv, 32'(i + 1));
    end
    check("ctrl_o_live", ctrl_o, 32'd1);
    check("cfg_o_live", cfg_o, 32'd2);

    // 3: byte strobes on SCRATCH0.
    axi_write(4'h8, 32'hAABBCCDD, 4'hF, 0, 0);
    axi_write(4'h8, 32'h11223344, 4'b0101, 0, 0);
    axi_write(4'h8, 32'hFFFFFFFF, 4'b0000, 0, 0);
    axi_read(4'h8, 0, rdv);
    check("strobe_readback", rdv, 32'hAA22CC44);

    // 4: AW four cycles ahead of W, B backpressure with a second write waiting.
    snap = aw_seen;
    @(negedge clock);
    wr_present(4'hC, 32'h0BADF00D, 4'hF, 4);
    wr_wait_hs(ok);
    @(negedge clock);
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    check("skew_bvalid", 32'(bus.s_axi_bvalid), 32'd1);
    bus.s_axi_awaddr  = 4'h8;
    bus.s_axi_wdata   = 32'h12345678;
    bus.s_axi_wstrb   = 4'hF;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid  = 1'b1;
    drops = 0;
    blocked = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (!bus.s_axi_bvalid) drops++;
      if (bus.s_axi_awready || bus.s_axi_wready) blocked++;
    end
    check("skew_single_accept", 32'(aw_seen - snap), 32'd1);
    check("bp_bvalid_held", 32'(drops), 32'd0);
    check("bp_no_accept", 32'(blocked), 32'd0);
    bus.s_axi_bready = 1'b1;
    @(negedge clock);
    bus.s_axi_bready = 1'b0;
    wr_wait_hs(ok);
    if (ok) wr_resp(0);
    axi_read(4'hC, 5, rdv);
    check("bp_read_c", rdv, 32'h0BADF00D);
    axi_read(4'h8, 0, rdv);
    check("bp_read_8", rdv, 32'h12345678);

    // 5: read capture and write commit on the same edge.
    axi_write(4'h4, 32'h5, 4'hF, 0, 0);
    fork
      axi_write(4'h4, 32'h9, 4'hF, 0, 0);
      axi_read(4'h4, 0, rdv);
    join
    check("collision_old_value", rdv, 32'h5);
    axi_read(4'h4, 0, rdv);
    check("collision_new_value", rdv, 32'h9);

    // 6: reset while a write response is pending.
    @(negedge clock);
    wr_present(4'h4, 32'hCAFE0001, 4'hF, 0);
    wr_wait_hs(ok);
    @(negedge clock);
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    check("midrst_bvalid_before", 32'(bus.s_axi_bvalid), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_bvalid_after", 32'(bus.s_axi_bvalid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    check("midrst_ctrl_o", ctrl_o, 32'd0);
    check("midrst_cfg_o", cfg_o, 32'd0);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), 0, rdv);
      check("midrst_readback", rdv, 32'd0);
    end
    axi_write(4'hC, 32'h600DBEEF, 4'hF, 0, 1);
    axi_read(4'hC, 1, rdv);
    check("midrst_recover", rdv, 32'h600DBEEF);

    // Randomized traffic against the register model.
    for (int it = 0; it < 60; it++) begin
      op   = int'($urandom_range(0, 2));
      a    = 4'($urandom);
      d    = $urandom;
      s    = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      skew = int'($urandom_range(0, 3));
      hold = int'($urandom_range(0, 3));
      if (op == 0) begin
        axi_write(a, d, s, skew, hold);
      end else if (op == 1) begin
        exp_rd = model[a[3:2]];
        axi_read(a, hold, rdv);
        check("rand_read", rdv, exp_rd);
      end else begin
        exp_rd = model[a[3:2]];
        fork
          axi_write(4'($urandom), d, s, skew, hold);
          axi_read(a, hold, rdv2);
        join
        check("rand_concurrent_read", rdv2, exp_rd);
      end
      check("rand_ctrl_o", ctrl_o, model[0]);
      check("rand_cfg_o", cfg_o, model[1]);
    end

    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4 + 3), 0, rdv);
      check("final_readback", rdv, model[i]);
    end

    repeat (2) @(negedge clock);
    check("early_ready", 32'(early_ready), 32'd0);
    check("aw_w_ready_together", 32'(ready_skew), 32'd0);
    check("aw_accept_count", 32'(aw_seen), 32'(wr_hs));
    check("start_pulse_count", 32'(start_seen), 32'(exp_start));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
